// File: rtl/sequenciador_movimento.sv
// Command-level motion sequencer: turns the robot to a heading, then advances N cells, tracking (x, y).
// Latency: first girar or avancar pulse two cycles after accept; done/erro pulse one cycle before IDLE.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while a command is in progress.
module sequenciador_movimento #(
    parameter int STEP_W   = 4,
    parameter int POS_W    = 4,
    parameter int GRID_MAX = 15,
    parameter int SETTLE   = 2
) (
    input  logic              clockc3,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [2:0]        orientacao,
    input  logic              obstaculo,
    input  logic              pos_clear,
    output logic              girar,
    output logic              avancar,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic [STEP_W-1:0] steps_left,
    output logic              busy,
    output logic              done,
    output logic              erro,
    output logic [1:0]        err_code
);

    localparam logic [2:0] DIR_N = 3'b001;
    localparam logic [2:0] DIR_O = 3'b010;
    localparam logic [2:0] DIR_L = 3'b011;
    localparam logic [2:0] DIR_S = 3'b100;

    localparam logic [1:0] ERR_DIR     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BLOCKED = 2'b11;

    // Wait counter counts SETTLE-1 down to 0, so it only needs to hold SETTLE-1.
    localparam int             CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  WAIT_LOAD = CW'(SETTLE - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(GRID_MAX);

    // Three turns always suffice; a fourth without a match means stuck feedback.
    localparam logic [2:0] MAX_TURNS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_TURN,
        S_SETTLE,
        S_MOVE,
        S_MOVE_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    logic [2:0]      target;
    logic [2:0]      turn_cnt;
    logic [CW-1:0]   wait_cnt;
    logic            blocked;

    function automatic logic dir_legal(input logic [2:0] d);
        return (d == DIR_N) || (d == DIR_O) || (d == DIR_L) || (d == DIR_S);
    endfunction

    assign cmd_ready = (state == S_IDLE);

    // Next advance is blocked by an obstacle or by the grid edge in the target heading.
    // It is evaluated in the cycle before MOVE so that avancar can be a registered pulse.
    always_comb begin
        blocked = obstaculo;
        case (target)
            DIR_N:   if (pos_y == POS_MAX)  blocked = 1'b1;
            DIR_S:   if (pos_y == '0)       blocked = 1'b1;
            DIR_L:   if (pos_x == POS_MAX)  blocked = 1'b1;
            DIR_O:   if (pos_x == '0)       blocked = 1'b1;
            default: blocked = 1'b1;
        endcase
    end

    // Command FSM with registered pulse outputs, position tracking and error reporting.
    always_ff @(posedge clockc3 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            target     <= '0;
            turn_cnt   <= '0;
            wait_cnt   <= '0;
            girar      <= 1'b0;
            avancar    <= 1'b0;
            pos_x      <= '0;
            pos_y      <= '0;
            steps_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            erro       <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            girar   <= 1'b0;
            avancar <= 1'b0;
            done    <= 1'b0;
            erro    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pos_clear) begin
                        pos_x <= '0;
                        pos_y <= '0;
                    end
                    if (cmd_valid) begin
                        target     <= cmd_dir;
                        steps_left <= cmd_steps;
                        turn_cnt   <= '0;
                        busy       <= 1'b1;
                        if (dir_legal(cmd_dir)) begin
                            err_code <= 2'b00;
                            state    <= S_CHECK;
                        end else begin
                            err_code <= ERR_DIR;
                            erro     <= 1'b1;
                            state    <= S_ERROR;
                        end
                    end
                end
                S_CHECK: begin
                    if (orientacao == target) begin
                        if (steps_left == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (blocked) begin
                            err_code <= ERR_BLOCKED;
                            erro     <= 1'b1;
                            state    <= S_ERROR;
                        end else begin
                            avancar <= 1'b1;
                            state   <= S_MOVE;
                        end
                    end else if (turn_cnt == MAX_TURNS) begin
                        err_code <= ERR_TIMEOUT;
                        erro     <= 1'b1;
                        state    <= S_ERROR;
                    end else begin
                        girar    <= 1'b1;
                        turn_cnt <= turn_cnt + 3'd1;
                        state    <= S_TURN;
                    end
                end
                S_TURN: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (wait_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_MOVE: begin
                    case (target)
                        DIR_N:   pos_y <= pos_y + POS_W'(1);
                        DIR_S:   pos_y <= pos_y - POS_W'(1);
                        DIR_L:   pos_x <= pos_x + POS_W'(1);
                        DIR_O:   pos_x <= pos_x - POS_W'(1);
                        default: ;
                    endcase
                    steps_left <= steps_left - STEP_W'(1);
                    wait_cnt   <= WAIT_LOAD;
                    state      <= S_MOVE_WAIT;
                end
                S_MOVE_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end else if (steps_left == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (blocked) begin
                        err_code <= ERR_BLOCKED;
                        erro     <= 1'b1;
                        state    <= S_ERROR;
                    end else begin
                        avancar <= 1'b1;
                        state   <= S_MOVE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_movimento.sv
// Testbench for sequenciador_movimento: directed commands against a robot orientation model.
// Expected pulses (with cycle offset from accept) are queued by the stimulus and popped by a monitor.
// Ends with a single summary line; every wait is cycle-bounded.
module tb_sequenciador_movimento;

    localparam logic [2:0] N = 3'b001;
    localparam logic [2:0] W = 3'b010;
    localparam logic [2:0] E = 3'b011;
    localparam logic [2:0] S = 3'b100;

    localparam int K_GIRAR = 0;
    localparam int K_AVANC = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERRO  = 3;

    logic       clockc3 = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_dir = 3'b000;
    logic [3:0] cmd_steps = 4'd0;
    logic [2:0] orientacao = N;
    logic       obstaculo = 1'b0;
    logic       pos_clear = 1'b0;
    logic       girar, avancar, busy, done, erro;
    logic [3:0] pos_x, pos_y, steps_left;
    logic [1:0] err_code;

    typedef struct {
        int kind;
        int rel;
        int x;
        int y;
        int s;
        int ec;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  acc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    bit  frozen = 1'b0;

    sequenciador_movimento #(
        .STEP_W(4), .POS_W(4), .GRID_MAX(15), .SETTLE(2)
    ) dut (
        .clockc3(clockc3), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .orientacao(orientacao), .obstaculo(obstaculo), .pos_clear(pos_clear),
        .girar(girar), .avancar(avancar),
        .pos_x(pos_x), .pos_y(pos_y), .steps_left(steps_left),
        .busy(busy), .done(done), .erro(erro), .err_code(err_code)
    );

    always #5 clockc3 = ~clockc3;

    always @(posedge clockc3) cyc <= cyc + 1;

    // Orientation FSM model: each girar rotates N->W->S->E->N unless the feedback is frozen.
    always @(negedge clockc3) begin
        if (girar && !frozen) begin
            case (orientacao)
                N:       orientacao = W;
                W:       orientacao = S;
                S:       orientacao = E;
                E:       orientacao = N;
                default: orientacao = N;
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        int  rel;
        rel = cyc - acc + 1;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d at rel=%0d, required no event", kind, rel);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.rel != rel ||
            (kind >= K_DONE && (int'(pos_x) != e.x || int'(pos_y) != e.y ||
                                int'(steps_left) != e.s || int'(err_code) != e.ec))) begin
            n_err++;
            $display("FAIL event: got kind=%0d rel=%0d x=%0d y=%0d s=%0d ec=%0d, required kind=%0d rel=%0d x=%0d y=%0d s=%0d ec=%0d",
                     kind, rel, pos_x, pos_y, steps_left, err_code,
                     e.kind, e.rel, e.x, e.y, e.s, e.ec);
        end
    endtask

    // Monitor: every output pulse is matched against the next queued expectation.
    always @(negedge clockc3) begin
        if (!reset) begin
            if (girar)   check_ev(K_GIRAR);
            if (avancar) check_ev(K_AVANC);
            if (done)    check_ev(K_DONE);
            if (erro)    check_ev(K_ERRO);
        end
    end

    task automatic push_pulse(input int kind, input int rel);
        ev_t e;
        e.kind = kind; e.rel = rel; e.x = 0; e.y = 0; e.s = 0; e.ec = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int kind, input int rel, input int x, input int y,
                            input int s, input int ec);
        ev_t e;
        e.kind = kind; e.rel = rel; e.x = x; e.y = y; e.s = s; e.ec = ec;
        exp_q.push_back(e);
    endtask

    // Drives one command for exactly one edge; returns #1 after the accepting edge.
    task automatic issue(input string nm, input logic [2:0] d, input logic [3:0] s, input logic clr);
        chk({nm, "_ready_before"}, int'(cmd_ready), 1);
        cmd_dir = d; cmd_steps = s; pos_clear = clr; cmd_valid = 1'b1;
        @(posedge clockc3); #1;
        acc = cyc;
        cmd_valid = 1'b0; pos_clear = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clockc3); #1;
            n++;
        end
        chk({nm, "_ready"}, int'(cmd_ready), 1);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clockc3); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clockc3);
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_girar", int'(girar), 0);
        chk("rst_avancar", int'(avancar), 0);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_steps", int'(steps_left), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_erro", int'({done, erro}), 0);
        chk("rst_err_code", int'(err_code), 0);
        reset = 1'b0;
        @(posedge clockc3); #1;

        // 1: already facing north, three steps north.
        push_pulse(K_AVANC, 2); push_pulse(K_AVANC, 5); push_pulse(K_AVANC, 8);
        push_end(K_DONE, 11, 0, 3, 0, 0);
        issue("t1", N, 4'd3, 1'b0);
        chk("t1_busy", int'(busy), 1);
        wait_idle("t1");
        chk("t1_pos_y", int'(pos_y), 3);

        // 2: turn-only, north to east is three rotations.
        push_pulse(K_GIRAR, 2); push_pulse(K_GIRAR, 6); push_pulse(K_GIRAR, 10);
        push_end(K_DONE, 14, 0, 3, 0, 0);
        issue("t2", E, 4'd0, 1'b0);
        wait_idle("t2");

        // 3: illegal heading code.
        push_end(K_ERRO, 1, 0, 3, 0, 1);
        issue("t3", 3'b111, 4'd0, 1'b0);
        @(posedge clockc3); #1;
        chk("t3_ready_rel2", int'(cmd_ready), 1);
        wait_idle("t3");
        chk("t3_err_code_held", int'(err_code), 1);

        // 4: return to north, then stuck feedback times out after four turns.
        push_pulse(K_GIRAR, 2);
        push_end(K_DONE, 6, 0, 3, 0, 0);
        issue("t4a", N, 4'd0, 1'b0);
        wait_idle("t4a");
        frozen = 1'b1;
        push_pulse(K_GIRAR, 2); push_pulse(K_GIRAR, 6);
        push_pulse(K_GIRAR, 10); push_pulse(K_GIRAR, 14);
        push_end(K_ERRO, 18, 0, 3, 1, 2);
        issue("t4", S, 4'd1, 1'b0);
        wait_idle("t4");
        frozen = 1'b0;

        // 5a: facing west at x=0 is blocked by the grid edge.
        push_pulse(K_GIRAR, 2);
        push_end(K_ERRO, 6, 0, 3, 2, 3);
        issue("t5a", W, 4'd2, 1'b0);
        wait_idle("t5a");
        chk("t5a_steps", int'(steps_left), 2);

        // 5b: clear coinciding with accept, then five cells east.
        push_pulse(K_GIRAR, 2); push_pulse(K_GIRAR, 6);
        push_pulse(K_AVANC, 10); push_pulse(K_AVANC, 13); push_pulse(K_AVANC, 16);
        push_pulse(K_AVANC, 19); push_pulse(K_AVANC, 22);
        push_end(K_DONE, 25, 5, 0, 0, 0);
        issue("t5b", E, 4'd5, 1'b1);
        wait_idle("t5b");

        // 5c: obstacle appears after the first step; pos_clear while busy is ignored.
        push_pulse(K_AVANC, 2);
        push_end(K_ERRO, 5, 6, 0, 2, 3);
        issue("t5c", E, 4'd3, 1'b0);
        @(posedge clockc3); #1;
        obstaculo = 1'b1; pos_clear = 1'b1;
        @(posedge clockc3); #1;
        pos_clear = 1'b0;
        wait_idle("t5c");
        obstaculo = 1'b0;
        chk("t5c_pos_x", int'(pos_x), 6);
        chk("t5c_steps", int'(steps_left), 2);

        // 6: reset during the second MOVE_WAIT of a five-step command.
        push_pulse(K_GIRAR, 2); push_pulse(K_AVANC, 6); push_pulse(K_AVANC, 9);
        issue("t6", N, 4'd5, 1'b0);
        repeat (9) @(posedge clockc3);
        #1;
        chk("t6_busy_before", int'(busy), 1);
        chk("t6_pos_y_before", int'(pos_y), 2);
        reset = 1'b1;
        #1;
        chk("t6_rst_girar", int'(girar), 0);
        chk("t6_rst_avancar", int'(avancar), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pos_x", int'(pos_x), 0);
        chk("t6_rst_pos_y", int'(pos_y), 0);
        chk("t6_queue_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clockc3);
        #1;
        reset = 1'b0;
        @(posedge clockc3); #1;
        chk("t6_ready_after", int'(cmd_ready), 1);
        push_pulse(K_AVANC, 2);
        push_end(K_DONE, 5, 0, 1, 0, 0);
        issue("t6b", N, 4'd1, 1'b0);
        wait_idle("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequenciador_movimento.md
Name: sequenciador_movimento

Overview:
- Command-level motion controller for the pipe-cleaner robot.
- Accepts a (heading, step-count) command over a valid/ready handshake.
- Turns the robot with one-cycle `girar` pulses to the orientation FSM until its `orientacao` feedback matches the requested heading, then issues one-cycle `avancar` pulses to the drive.
- Tracks grid position (x, y) and reports done or error.

Parameters:
- STEP_W, 4, width of the step-count field.
- POS_W, 4, width of the position counters.
- GRID_MAX, 15, highest legal coordinate on each axis (≤ 2^POS_W−1).
- SETTLE, 2, wait cycles after every `girar` or `avancar` pulse before the next decision (≥1).

Ports:
- clockc3  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_dir  in  3  target heading: Norte=001, Oeste=010, Leste=011, Sul=100
- cmd_steps  in  STEP_W  cells to advance after turning (0 = turn only)
- orientacao  in  3  current heading feedback from the orientation FSM
- obstaculo  in  1  obstacle directly ahead (level)
- pos_clear  in  1  zero the position counters; honoured only in IDLE
- girar  out  1  one-cycle rotate request; rotation order N→W→S→E→N
- avancar  out  1  one-cycle advance-one-cell request
- pos_x  out  POS_W  current x coordinate
- pos_y  out  POS_W  current y coordinate
- steps_left  out  STEP_W  steps still pending for the current command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on successful completion
- erro  out  1  one-cycle pulse on abort
- err_code  out  2  00 none, 01 illegal dir, 10 turn timeout, 11 blocked

Behaviour:
- Reset values: state=IDLE, girar=0, avancar=0, pos_x=0, pos_y=0, steps_left=0, busy=0, done=0, erro=0, err_code=00, turn counter=0. cmd_ready=1 (decoded from IDLE).
- An asynchronous reset mid-command drops girar/avancar immediately and discards the command. No pending pulse is re-issued.
- All outputs are registered or state-decoded; no combinational path from inputs to girar/avancar.
- cmd_ready=1 only in IDLE.
- Accept on the clockc3 edge where cmd_valid && cmd_ready. Latch cmd_dir → target, cmd_steps → steps_left, clear err_code and the turn counter. busy=1 from the next cycle until return to IDLE.
- pos_clear in IDLE zeroes pos_x/pos_y. If it coincides with an accept, the clear happens first.
- States:
  - IDLE: wait for accept → CHECK. If target is not one of the 4 legal codes → ERROR, err_code=01.
  - CHECK: if orientacao==target → (steps_left==0 ? DONE : MOVE). Else if turn counter==4 → ERROR, err_code=10. Else → TURN.
  - TURN: girar=1 for exactly this cycle, turn counter +1 → SETTLE.
  - SETTLE: wait SETTLE cycles → CHECK.
  - MOVE: evaluate obstaculo and the boundary in this cycle.
    - Blocked if obstaculo=1, or heading Norte with pos_y==GRID_MAX, Sul with pos_y==0, Leste with pos_x==GRID_MAX, or Oeste with pos_x==0. Blocked → ERROR, err_code=11, no pulse, steps_left unchanged.
    - Otherwise avancar=1 for this cycle. Update position (Norte y+1, Sul y−1, Leste x+1, Oeste x−1), steps_left −1 → MOVE_WAIT.
  - MOVE_WAIT: wait SETTLE cycles → (steps_left==0 ? DONE : MOVE).
  - DONE: done=1 one cycle → IDLE.
  - ERROR: erro=1 one cycle → IDLE. err_code holds until the next accept.
- Heading is re-checked only via CHECK, so turns happen before moves.
- Pulse spacing:
  - Consecutive girar pulses are SETTLE+2 cycles apart (TURN, SETTLE×SETTLE, CHECK).
  - Consecutive avancar pulses are SETTLE+1 cycles apart.
- At most 3 turns are ever needed. A 4th pulse without a match means the feedback is stuck → timeout.
- Position never wraps; the boundary check prevents overflow and underflow. Position persists across commands.
- Ignored inputs: cmd_valid while busy, and pos_clear outside IDLE.

Test Plan:
1. Reset; orientation model at Norte; cmd Norte/3 → no girar; avancar at accept+2, +5, +8 (SETTLE=2); pos_y=3, pos_x=0; done pulse; cmd_ready back to 1.
2. From Norte, cmd Leste/0 → exactly 3 girar pulses 4 cycles apart (N→W→S→E); done; position unchanged; turn-only path with steps=0.
3. cmd_dir=111 → erro pulse, err_code=01, no girar/avancar, cmd_ready=1 two cycles after accept.
4. Orientation model frozen at Norte, cmd Sul/1 → 4 girar pulses, then erro with err_code=10; avancar never asserted.
5. pos_x=0, heading Oeste, cmd Oeste/2 → erro with err_code=11, zero avancar, steps_left=2. Then from x=5, cmd Leste/3 with obstaculo raised after the first pulse → one avancar, pos_x=6, steps_left=2, err_code=11.
6. Assert reset during MOVE_WAIT of a 5-step command → girar/avancar/busy=0 and pos=0,0 immediately; IDLE with cmd_ready=1 after release; a new command is accepted normally.
